sha2_host_ctrl: RTL and testbench

Host-side requester for the single-block SHA-256 wrapper. It accepts a message as a byte stream, packs it into the wrapper's 448-bit plaintext bus, and issues the wrapper command word with its one-cycle start bit. It tracks the wrapper's busy/done status updates, captures the digest on the wrapper's regwrite pulse, and streams the digest out as eight 32-bit words.

---
 rtl/sha2_host_ctrl.sv | 157 +++++++++++++++
 tb/tb_sha2_host_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_host_ctrl.sv
// Host-side requester for the single-block SHA-256 wrapper: packs a byte stream, issues the start command, streams the digest out.
// Optional watchdog: define SHA2_HOST_TIMEOUT_EN to abandon a hash after TIMEOUT_CYCLES waiting cycles.
module sha2_host_ctrl #(
  parameter int MAX_BYTES      = 55,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic         error,
  output logic [447:0] sha2_plaintext,
  output logic [66:0]  sha2_csr,
  input  logic [2:0]   sha2_status,
  input  logic         sha2_csr_update,
  input  logic         sha2_regwrite,
  input  logic [255:0] sha2_digest
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_DRAIN     = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_OUT       = 3'd6;

  logic [2:0]    r_state;
  logic [CW-1:0] r_count;
  logic [447:0]  r_plaintext;
  logic [255:0]  r_digest;
  logic [2:0]    r_wordIdx;
  logic          r_error;

  logic          w_lenActive;
  logic [63:0]   w_lenBits;
  logic [7:0]    w_wordBase;
  logic          w_busyUpd;
  logic          w_doneUpd;

  // in_ready is gated by reset so it reads 0 while reset is held low
  assign in_ready    = reset && (r_state == S_IDLE || r_state == S_LOAD || r_state == S_DRAIN);
  assign w_lenActive = (r_state == S_START) || (r_state == S_WAIT_BUSY) ||
                       (r_state == S_WAIT_DONE) || (r_state == S_OUT);
  assign w_lenBits   = 64'(r_count) << 3;
  assign sha2_csr    = w_lenActive ? {w_lenBits, (r_state == S_START), 2'b00} : '0;
  assign sha2_plaintext = r_plaintext;

  // Word k sits at bit offset (7-k)*32, and for a 3-bit index 7-k is just ~k
  assign w_wordBase = {~r_wordIdx, 5'b0};
  assign out_data   = r_digest[w_wordBase +: 32];
  assign out_valid  = (r_state == S_OUT);
  assign out_last   = (r_state == S_OUT) && (r_wordIdx == 3'd7);
  assign busy       = (r_state != S_IDLE);
  assign error      = r_error;

  assign w_busyUpd = sha2_csr_update && (sha2_status == 3'd2);
  assign w_doneUpd = sha2_csr_update && (sha2_status == 3'd1);

`ifdef SHA2_HOST_TIMEOUT_EN
  logic [31:0] r_timer;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_plaintext <= '0;
      r_digest    <= '0;
      r_wordIdx   <= '0;
      r_error     <= 1'b0;
`ifdef SHA2_HOST_TIMEOUT_EN
      r_timer     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_plaintext <= {440'b0, in_data};
            r_count     <= CW'(1);
            r_error     <= 1'b0;
            r_state     <= in_last ? S_START : S_LOAD;
          end else if (in_last) begin
            r_plaintext <= '0;
            r_count     <= '0;
            r_state     <= S_START;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (r_count == CW'(MAX_BYTES)) begin
              r_error     <= 1'b1;
              r_plaintext <= '0;
              r_count     <= '0;
              r_state     <= in_last ? S_IDLE : S_DRAIN;
            end else begin
              r_plaintext <= {r_plaintext[439:0], in_data};
              r_count     <= r_count + CW'(1);
              if (in_last) r_state <= S_START;
            end
          end
        end
        S_DRAIN: begin
          if (in_valid && in_last) r_state <= S_IDLE;
        end
        S_START: r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (w_busyUpd) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (sha2_regwrite) r_digest <= sha2_digest;
          if (w_doneUpd) r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            if (r_wordIdx == 3'd7) begin
              r_state     <= S_IDLE;
              r_wordIdx   <= '0;
              r_plaintext <= '0;
              r_count     <= '0;
            end else begin
              r_wordIdx <= r_wordIdx + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

`ifdef SHA2_HOST_TIMEOUT_EN
      // Placed after the case so an expiry overrides any transition taken this cycle
      if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) begin
        if (r_timer == 32'(TIMEOUT_CYCLES - 1)) begin
          r_error     <= 1'b1;
          r_state     <= S_IDLE;
          r_plaintext <= '0;
          r_count     <= '0;
          r_timer     <= '0;
        end else begin
          r_timer <= r_timer + 32'd1;
        end
      end else begin
        r_timer <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sha2_host_ctrl.sv
// Directed self-checking bench for sha2_host_ctrl; the bench plays the SHA-256 wrapper with known digests.
module tb_sha2_host_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         error;
  logic [447:0] sha2_plaintext;
  logic [66:0]  sha2_csr;
  logic [2:0]   sha2_status = '0;
  logic         sha2_csr_update = 1'b0;
  logic         sha2_regwrite = 1'b0;
  logic [255:0] sha2_digest = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0] msgBuf [0:63];
  int         msgLen;

  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [447:0] ABC_PLAIN = 448'h616263;

  sha2_host_ctrl #(.MAX_BYTES(55), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .error(error),
    .sha2_plaintext(sha2_plaintext), .sha2_csr(sha2_csr),
    .sha2_status(sha2_status), .sha2_csr_update(sha2_csr_update),
    .sha2_regwrite(sha2_regwrite), .sha2_digest(sha2_digest)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [447:0] obs, input logic [447:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic loadAbc();
    msgBuf[0] = 8'h61; msgBuf[1] = 8'h62; msgBuf[2] = 8'h63; msgLen = 3;
  endtask

  task automatic loadFill(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) msgBuf[i] = b;
    msgLen = n;
  endtask

  // Sends msgBuf (or an empty-message request) and returns on the negedge after the last acceptance
  task automatic applyStimulus();
    if (msgLen == 0) begin
      @(negedge clock);
      checkOutput("inReadyIdle", in_ready, 1);
      in_last = 1'b1;
    end else begin
      for (int i = 0; i < msgLen; i++) begin
        @(negedge clock);
        checkOutput($sformatf("inReady%0d", i), in_ready, 1);
        in_valid = 1'b1;
        in_data  = msgBuf[i];
        in_last  = (i == msgLen - 1);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic startCheck(input logic [63:0] expLen, input logic [447:0] expPlain);
    checkOutput("startBit", sha2_csr[2], 1);
    checkOutput("csrLen", sha2_csr[66:3], expLen);
    checkOutput("csrLow", sha2_csr[1:0], 0);
    checkOutput("plaintext", sha2_plaintext, expPlain);
    checkOutput("inReadyStart", in_ready, 0);
    checkOutput("busyStart", busy, 1);
    checkOutput("errorStart", error, 0);
  endtask

  // Plays the wrapper: two busy updates, optional regwrite, then the done update
  task automatic wrapperRun(input logic [255:0] dig, input bit sameCycle, input bit giveRegwrite,
                            input logic [63:0] expLen);
    @(negedge clock);
    checkOutput("startOnce", sha2_csr[2], 0);
    checkOutput("lenHeld", sha2_csr[66:3], expLen);
    sha2_csr_update = 1'b1; sha2_status = 3'd2;
    @(negedge clock);
    @(negedge clock);
    sha2_csr_update = 1'b0; sha2_status = 3'd0;
    @(negedge clock);
    checkOutput("noOutBeforeDone", out_valid, 0);
    if (giveRegwrite) begin
      sha2_regwrite = 1'b1;
      sha2_digest   = dig;
    end
    if (sameCycle) begin
      sha2_csr_update = 1'b1; sha2_status = 3'd1;
    end
    @(negedge clock);
    sha2_regwrite   = 1'b0;
    sha2_digest     = ~dig;
    sha2_csr_update = 1'b0;
    if (!sameCycle) begin
      sha2_csr_update = 1'b1; sha2_status = 3'd1;
      @(negedge clock);
      sha2_csr_update = 1'b0;
    end
    sha2_status = 3'd0;
    checkOutput("outValidRise", out_valid, 1);
  endtask

  task automatic readDigest(input logic [255:0] exp, input bit toggle);
    int k = 0;
    int cyc = 0;
    while (k < 8 && cyc < 64) begin
      checkOutput("outValid", out_valid, 1);
      checkOutput($sformatf("word%0d", k), out_data, exp[255 - 32*k -: 32]);
      checkOutput($sformatf("outLast%0d", k), out_last, (k == 7));
      out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      @(negedge clock);
      if (out_ready) k++;
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput("wordCount", k, 8);
    checkOutput("outValidEnd", out_valid, 0);
    checkOutput("busyEnd", busy, 0);
    checkOutput("csrEnd", sha2_csr, 0);
    checkOutput("plainEnd", sha2_plaintext, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("rstInReady", in_ready, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstCsr", sha2_csr, 0);
    checkOutput("rstPlain", sha2_plaintext, 0);
    checkOutput("rstError", error, 0);
    reset = 1'b1;

    $display("[TB] abc message");
    loadAbc();
    applyStimulus();
    startCheck(64'd24, ABC_PLAIN);
    wrapperRun(ABC_DIG, 1'b0, 1'b1, 64'd24);
    readDigest(ABC_DIG, 1'b0);

    $display("[TB] empty message, regwrite and done together");
    msgLen = 0;
    applyStimulus();
    startCheck(64'd0, '0);
    wrapperRun(EMPTY_DIG, 1'b1, 1'b1, 64'd0);
    readDigest(EMPTY_DIG, 1'b0);

    $display("[TB] 56-byte overflow");
    loadFill(8'h00, 56);
    applyStimulus();
    checkOutput("ovfNoStart", sha2_csr[2], 0);
    checkOutput("ovfError", error, 1);
    checkOutput("ovfBusy", busy, 0);
    checkOutput("ovfInReady", in_ready, 1);

    $display("[TB] abc after overflow with stalling consumer");
    loadAbc();
    applyStimulus();
    startCheck(64'd24, ABC_PLAIN);
    wrapperRun(ABC_DIG, 1'b0, 1'b1, 64'd24);
    readDigest(ABC_DIG, 1'b1);

    $display("[TB] 58-byte overflow with drain");
    loadFill(8'h11, 58);
    applyStimulus();
    checkOutput("drainNoStart", sha2_csr[2], 0);
    checkOutput("drainError", error, 1);
    checkOutput("drainBusy", busy, 0);
    checkOutput("drainPlain", sha2_plaintext, 0);

    $display("[TB] reset during WAIT_DONE then late regwrite");
    loadAbc();
    applyStimulus();
    startCheck(64'd24, ABC_PLAIN);
    @(negedge clock);
    sha2_csr_update = 1'b1; sha2_status = 3'd2;
    @(negedge clock);
    sha2_csr_update = 1'b0; sha2_status = 3'd0;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midRstInReady", in_ready, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstCsr", sha2_csr, 0);
    checkOutput("midRstPlain", sha2_plaintext, 0);
    checkOutput("midRstOutValid", out_valid, 0);
    reset = 1'b1;
    sha2_regwrite = 1'b1;
    sha2_digest   = 256'hdeadbeef;
    @(negedge clock);
    sha2_regwrite = 1'b0;
    checkOutput("lateRwBusy", busy, 0);
    checkOutput("lateRwOutValid", out_valid, 0);
    checkOutput("lateRwInReady", in_ready, 1);
    // A hash with no regwrite exposes the digest register, which must still be cleared
    msgLen = 0;
    applyStimulus();
    startCheck(64'd0, '0);
    wrapperRun(EMPTY_DIG, 1'b0, 1'b0, 64'd0);
    readDigest('0, 1'b0);

`ifdef SHA2_HOST_TIMEOUT_EN
    $display("[TB] timeout with silent wrapper");
    loadAbc();
    applyStimulus();
    startCheck(64'd24, ABC_PLAIN);
    repeat (20) @(negedge clock);
    checkOutput("toError", error, 1);
    checkOutput("toBusy", busy, 0);
    checkOutput("toOutValid", out_valid, 0);
    checkOutput("toCsr", sha2_csr, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
